cache_fill_ctrl: RTL and testbench
==================================

# cache_fill_ctrl

Parametrised cache block-fill controller sitting between the L1 cache tag/data arrays and the pipelined main-memory model. On a miss it captures the miss address and issues one word request per cycle for the whole block. It collects returning words independently of issue and writes each into the data array. It then writes the tag and releases the pipeline stall. Block size, data width, address width and, optionally, critical-word-first ordering are configurable.

## Interface
Parameters:
- ADDR_W, 16, byte-address width
- DATA_W, 16, memory word width in bits; a power of two, at least 8
- WORDS, 8, words per cache block; a power of two, at least 2
- Derived: BYTES_W = log2(DATA_W/8), IDX_W = log2(WORDS), OFF_W = IDX_W + BYTES_W

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- miss_detected  in  1  cache miss present this cycle
- miss_address  in  ADDR_W  byte address of the missing access
- mem_data_in  in  DATA_W  read data from memory
- mem_data_valid  in  1  mem_data_in valid; one word per pulse, in issue order
- fsm_busy  out  1  pipeline stall request
- mem_req  out  1  read request; memory always accepts
- mem_addr  out  ADDR_W  request byte address
- write_data_array  out  1  write fill_data into the data array at fill_word_idx
- fill_word_idx  out  IDX_W  word index within the block being written
- fill_data  out  DATA_W  equal to mem_data_in
- write_tag_array  out  1  single-cycle tag/valid write strobe

## Operation
- Registered state:
  - state: IDLE, FILL, WAIT or TAG
  - base address: miss_address with the low OFF_W bits cleared
  - start index: IDX_W bits
  - issue counter iss_cnt: IDX_W+1 bits
  - receive counter rcv_cnt: IDX_W+1 bits
- IDLE:
  - When miss_detected = 1, capture the base address and start index, clear both counters, and go to FILL.
  - mem_data_valid is ignored.
- FILL:
  - mem_req = 1.
  - mem_addr = base | ((start + iss_cnt) mod WORDS) << BYTES_W.
  - iss_cnt increments every cycle.
  - After the request with iss_cnt = WORDS-1, go to WAIT. If receive also completes in that cycle, go to TAG instead.
- WAIT:
  - mem_req = 0.
  - When rcv_cnt reaches WORDS, go to TAG.
- Receive, in FILL and WAIT:
  - Each mem_data_valid with rcv_cnt < WORDS asserts write_data_array in the same cycle.
  - fill_word_idx = (start + rcv_cnt) mod WORDS.
  - rcv_cnt then increments.
  - Excess valid pulses are ignored.
- TAG:
  - write_tag_array = 1 for exactly one cycle, then go to IDLE.
- fsm_busy = (state != IDLE) | (state == IDLE & miss_detected). Forced to 0 while rst_n = 0.
- miss_detected and miss_address are ignored outside IDLE. The captured address is held for the whole fill.
- Index arithmetic wraps modulo WORDS; no carry into the base address.

## Timing
- Reset values:
  - state IDLE, counters 0, base address 0
  - mem_req 0, mem_addr 0
  - write_data_array 0, write_tag_array 0, fill_word_idx 0
  - fsm_busy 0
- An asynchronous reset mid-fill aborts immediately. No tag write occurs and partial data-array writes are not undone.
- With the miss in IDLE at cycle 0 and memory latency L ≥ 1:
  - Requests go out in cycles 1..WORDS.
  - Word k returns in cycle 1+k+L.
  - TAG is in cycle WORDS+L+1; IDLE is in cycle WORDS+L+2.
  - fsm_busy is high in cycles 0..WORDS+L+1.
- The controller is correct for any mem_data_valid spacing, provided words arrive in order and no earlier than the cycle after their request.
- A new miss is accepted in the first IDLE cycle after TAG.

## Configuration
- CRITICAL_WORD_FIRST_EN defined:
  - start index = miss_address[OFF_W-1:BYTES_W].
  - Issue and fill begin at the missed word and wrap around the block.
- Not defined:
  - start index is forced to 0.
  - Words are issued and written in ascending order 0..WORDS-1.
  - The miss_address offset bits are ignored.

## Test plan
- Default parameters, macro undefined, miss at 0x1236, memory with L = 4:
  - mem_addr runs 0x1230, 0x1232 … 0x123E in cycles 1-8.
  - Eight write_data_array pulses with idx 0..7.
  - write_tag_array in cycle 13; fsm_busy falls in cycle 14.
- Macro defined, miss at 0x123A:
  - Issue order 0x123A, 0x123C, 0x123E, 0x1230 … 0x1238.
  - fill_word_idx sequence 5, 6, 7, 0, 1, 2, 3, 4.
- Variable memory latency with gaps of 0-3 idle cycles between valids:
  - Exactly WORDS data writes.
  - write_tag_array fires the cycle after the final valid.
  - A ninth, spurious valid is ignored.
- Second miss held high through the fill with a different address:
  - The first fill is unaffected.
  - The new miss starts in the first IDLE cycle after TAG.
- rst_n pulsed low in WAIT after 3 words received:
  - All outputs return to their reset values asynchronously.
  - No write_tag_array.
  - A subsequent miss performs a clean full fill.
- DATA_W = 32, WORDS = 4, miss at 0x00F4:
  - Addresses 0x00F0, 0x00F4, 0x00F8, 0x00FC, or 0x00F4, 0x00F8, 0x00FC, 0x00F0 with the macro defined.

Source files
------------

// File: rtl/cache_fill_ctrl.sv
// Cache block-fill controller: captures a miss, issues one word request per cycle,
// writes returning words into the data array, then strobes the tag write.
// Critical-word-first ordering is enabled by defining CRITICAL_WORD_FIRST_EN.
module cache_fill_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     miss_detected,
  input  logic [ADDR_W-1:0]        miss_address,
  input  logic [DATA_W-1:0]        mem_data_in,
  input  logic                     mem_data_valid,
  output logic                     fsm_busy,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     write_data_array,
  output logic [$clog2(WORDS)-1:0] fill_word_idx,
  output logic [DATA_W-1:0]        fill_data,
  output logic                     write_tag_array
);
  localparam int BYTES_W = $clog2(DATA_W / 8);
  localparam int IDX_W   = $clog2(WORDS);
  localparam int OFF_W   = IDX_W + BYTES_W;
  localparam int CNT_W   = IDX_W + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] TAG  = 2'd3;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WORDS);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  function automatic logic [ADDR_W-1:0] word_offset(input logic [IDX_W-1:0] idx);
    word_offset = ADDR_W'(idx) << BYTES_W;
  endfunction

  logic [1:0]        state_r, state_s;
  logic [ADDR_W-1:0] base_r, base_s;
  logic [IDX_W-1:0]  start_r, start_s;
  logic [CNT_W-1:0]  iss_cnt_r, iss_cnt_s;
  logic [CNT_W-1:0]  rcv_cnt_r, rcv_cnt_s;
  logic [IDX_W-1:0]  miss_start_s;
  logic [IDX_W-1:0]  iss_idx_s;
  logic [IDX_W-1:0]  rcv_idx_s;
  logic              accept_s;
  logic              rcv_done_s;

`ifdef CRITICAL_WORD_FIRST_EN
  assign miss_start_s = miss_address[OFF_W-1:BYTES_W];
`else
  assign miss_start_s = '0;
`endif

  // Index sums are IDX_W wide so they wrap inside the block, never carrying into the base.
  assign iss_idx_s  = start_r + iss_cnt_r[IDX_W-1:0];
  assign rcv_idx_s  = start_r + rcv_cnt_r[IDX_W-1:0];
  assign accept_s   = mem_data_valid & ((state_r == FILL) | (state_r == WAIT)) & (rcv_cnt_r < CNT_FULL);
  assign rcv_done_s = (rcv_cnt_r == CNT_FULL) | ((rcv_cnt_r == CNT_LAST) & accept_s);

  // Next-state, capture and counter logic.
  always_comb begin
    state_s   = state_r;
    base_s    = base_r;
    start_s   = start_r;
    iss_cnt_s = iss_cnt_r;
    rcv_cnt_s = rcv_cnt_r;
    if (accept_s) begin
      rcv_cnt_s = rcv_cnt_r + CNT_W'(1);
    end else begin
      rcv_cnt_s = rcv_cnt_r;
    end
    case (state_r)
      IDLE: begin
        if (miss_detected) begin
          base_s    = miss_address & ~OFF_MASK;
          start_s   = miss_start_s;
          iss_cnt_s = '0;
          rcv_cnt_s = '0;
          state_s   = FILL;
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        iss_cnt_s = iss_cnt_r + CNT_W'(1);
        if (iss_cnt_r == CNT_LAST) begin
          state_s = rcv_done_s ? TAG : WAIT;
        end else begin
          state_s = FILL;
        end
      end
      WAIT: begin
        if (rcv_done_s) begin
          state_s = TAG;
        end else begin
          state_s = WAIT;
        end
      end
      TAG: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any fill in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      base_r    <= '0;
      start_r   <= '0;
      iss_cnt_r <= '0;
      rcv_cnt_r <= '0;
    end else begin
      state_r   <= state_s;
      base_r    <= base_s;
      start_r   <= start_s;
      iss_cnt_r <= iss_cnt_s;
      rcv_cnt_r <= rcv_cnt_s;
    end
  end

  // Outputs decode from registered state; data-array writes follow the returning word.
  always_comb begin
    if (state_r == FILL) begin
      mem_req  = 1'b1;
      mem_addr = base_r | word_offset(iss_idx_s);
    end else begin
      mem_req  = 1'b0;
      mem_addr = '0;
    end
  end

  assign write_data_array = accept_s;
  assign fill_word_idx    = rcv_idx_s;
  assign fill_data        = mem_data_in;
  assign write_tag_array  = (state_r == TAG);
  assign fsm_busy         = rst_n & ((state_r != IDLE) | miss_detected);

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl: table-driven fills against a latency/gap memory
// model with scoreboard queues, plus hand-written hold-miss, reset-abort and 32-bit/4-word cases.
module tb_cache_fill_ctrl;
  localparam int WORDS = 8;
`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] mem_data_in;
  logic        mem_data_valid;
  logic        fsm_busy, mem_req, write_data_array, write_tag_array;
  logic [15:0] mem_addr, fill_data;
  logic [2:0]  fill_word_idx;

  logic        m2_miss, m2_valid;
  logic [15:0] m2_addr;
  logic [31:0] m2_data;
  logic        b2_busy, b2_req, b2_wr, b2_tag;
  logic [15:0] b2_mem_addr;
  logic [1:0]  b2_idx;
  logic [31:0] b2_fill_data;

  cache_fill_ctrl dut (
    .clk(clk), .rst_n(rst_n), .miss_detected(miss_detected), .miss_address(miss_address),
    .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid), .fsm_busy(fsm_busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .write_data_array(write_data_array),
    .fill_word_idx(fill_word_idx), .fill_data(fill_data), .write_tag_array(write_tag_array)
  );

  cache_fill_ctrl #(.ADDR_W(16), .DATA_W(32), .WORDS(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .miss_detected(m2_miss), .miss_address(m2_addr),
    .mem_data_in(m2_data), .mem_data_valid(m2_valid), .fsm_busy(b2_busy),
    .mem_req(b2_req), .mem_addr(b2_mem_addr), .write_data_array(b2_wr),
    .fill_word_idx(b2_idx), .fill_data(b2_fill_data), .write_tag_array(b2_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model and scoreboard state
  int          req_due[$];
  logic [15:0] req_addr[$];
  logic [15:0] exp_addr_q[$];
  logic [2:0]  exp_idx_q[$];
  logic [15:0] exp_data_q[$];
  int mem_lat = 1, mem_gap = 0, last_due = 0;
  bit mem_spur = 1'b0, spur_pending = 1'b0;
  int words_driven = 0, last_valid_cyc = 0, wr_cnt = 0, busy_cnt = 0;
  int tag_cnt = 0, tag_cyc = 0, first_req_cyc = 0;
  bit first_req_seen = 1'b0;
  logic [15:0] first_req_addr = 16'h0;

  task automatic push_expect(input logic [15:0] a);
    logic [2:0] start;
    logic [2:0] idx;
    start = CWF ? a[3:1] : 3'd0;
    for (int k = 0; k < WORDS; k++) begin
      idx = start + 3'(k);
      exp_idx_q.push_back(idx);
      exp_addr_q.push_back({a[15:4], 4'h0} | {12'h0, idx, 1'b0});
    end
    words_driven = 0; wr_cnt = 0; busy_cnt = 0; last_due = 0;
    first_req_seen = 1'b0;
  endtask

  // Memory: returns each request after mem_lat cycles plus optional random gaps
  initial begin
    logic [15:0] a;
    mem_data_valid = 1'b0;
    mem_data_in = 16'h0;
    forever begin
      @(posedge clk); #1;
      if (req_due.size() > 0 && req_due[0] <= cyc) begin
        a = req_addr.pop_front();
        void'(req_due.pop_front());
        mem_data_valid = 1'b1;
        mem_data_in = a ^ 16'h5A5A;
        exp_data_q.push_back(mem_data_in);
        words_driven++;
        last_valid_cyc = cyc;
        if (words_driven == WORDS && mem_spur) spur_pending = 1'b1;
      end else if (spur_pending) begin
        spur_pending = 1'b0;
        mem_data_valid = 1'b1;
        mem_data_in = 16'hDEAD;
      end else begin
        mem_data_valid = 1'b0;
        mem_data_in = 16'h0;
      end
    end
  end

  // Sampler: compares requests and writes against the scoreboard on the falling edge
  initial begin
    int due, g;
    forever begin
      @(negedge clk);
      if (fsm_busy) busy_cnt++;
      if (mem_req) begin
        if (!first_req_seen) begin
          first_req_seen = 1'b1; first_req_addr = mem_addr; first_req_cyc = cyc;
        end
        if (exp_addr_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_req: addr %0h, expected no request", mem_addr);
        end else begin
          check("mem_addr", mem_addr, exp_addr_q.pop_front());
        end
        g = (mem_gap > 0) ? int'($urandom_range(mem_gap, 0)) : 0;
        due = cyc + mem_lat;
        if (due < last_due + 1 + g) due = last_due + 1 + g;
        last_due = due;
        req_due.push_back(due);
        req_addr.push_back(mem_addr);
      end
      if (write_data_array) begin
        wr_cnt++;
        if (exp_idx_q.size() == 0 || exp_data_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL spurious_write: idx %0d data %0h, expected no write", fill_word_idx, fill_data);
        end else begin
          check("fill_word_idx", 32'(fill_word_idx), 32'(exp_idx_q.pop_front()));
          check("fill_data", fill_data, exp_data_q.pop_front());
        end
      end
      if (write_tag_array) begin
        tag_cnt++;
        tag_cyc = cyc;
      end
    end
  end

  task automatic wait_tag(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (tag_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_fill(input logic [15:0] a, input int lat, input int gap, input bit spur,
                          input logic [15:0] exp_first, input int exp_tag_off);
    int c0, t0;
    bit ok;
    mem_lat = lat; mem_gap = gap; mem_spur = spur;
    @(posedge clk); #1;
    miss_detected = 1'b1; miss_address = a;
    push_expect(a);
    c0 = cyc; t0 = tag_cnt;
    @(negedge clk);
    check("busy_on_miss", 32'(fsm_busy), 32'd1);
    @(posedge clk); #1;
    miss_detected = 1'b0; miss_address = 16'h0;
    wait_tag(t0 + 1, 200, ok);
    check("tag_seen", 32'(ok), 32'd1);
    check("first_addr", first_req_addr, exp_first);
    check("first_req_cycle", first_req_cyc - c0, 32'd1);
    if (exp_tag_off >= 0) check("tag_cycle", tag_cyc - c0, exp_tag_off);
    else check("tag_after_last_valid", tag_cyc - last_valid_cyc, 32'd1);
    check("busy_cycles", busy_cnt, tag_cyc - c0 + 1);
    @(negedge clk); #1;
    check("busy_released", 32'(fsm_busy), 32'd0);
    check("write_count", wr_cnt, WORDS);
    check("addr_q_drained", exp_addr_q.size(), 32'd0);
    check("idx_q_drained", exp_idx_q.size(), 32'd0);
    repeat (3) @(negedge clk);
    check("single_tag", tag_cnt, t0 + 1);
  endtask

  typedef struct {
    logic [15:0] addr;
    int          lat;
    int          gap;
    bit          spur;
    logic [15:0] first_def;
    logic [15:0] first_cwf;
    int          tag_off;
  } fill_vec_t;

  fill_vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, t0;
    bit ok;
    logic [15:0] exp2_addr[4];
    logic [1:0]  exp2_idx[4];

    vecs[0] = '{16'h1236, 4, 0, 1'b0, 16'h1230, 16'h1236, 13};
    vecs[1] = '{16'h123A, 4, 0, 1'b0, 16'h1230, 16'h123A, 13};
    vecs[2] = '{16'hFFFE, 1, 0, 1'b0, 16'hFFF0, 16'hFFFE, 10};
    vecs[3] = '{16'h0000, 7, 0, 1'b0, 16'h0000, 16'h0000, 16};
    vecs[4] = '{16'h4567, 2, 3, 1'b1, 16'h4560, 16'h4566, -1};
    vecs[5] = '{16'h89AB, 1, 2, 1'b1, 16'h89A0, 16'h89AA, -1};

    rst_n = 1'b0; miss_detected = 1'b0; miss_address = 16'h0;
    m2_miss = 1'b0; m2_addr = 16'h0; m2_data = 32'h0; m2_valid = 1'b0;
    #2;
    check("rst_busy", 32'(fsm_busy), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wr", 32'(write_data_array), 32'd0);
    check("rst_tag", 32'(write_tag_array), 32'd0);
    check("rst_idx", 32'(fill_word_idx), 32'd0);
    miss_detected = 1'b1; miss_address = 16'h1236;
    #1;
    check("rst_busy_masks_miss", 32'(fsm_busy), 32'd0);
    miss_detected = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_fill(vecs[i].addr, vecs[i].lat, vecs[i].gap, vecs[i].spur,
               CWF ? vecs[i].first_cwf : vecs[i].first_def, vecs[i].tag_off);
    end

    // Miss held high with a new address through the whole fill
    mem_lat = 2; mem_gap = 0; mem_spur = 1'b0;
    @(posedge clk); #1;
    miss_detected = 1'b1; miss_address = 16'h5550;
    push_expect(16'h5550);
    c0 = cyc; t0 = tag_cnt;
    @(posedge clk); #1;
    miss_address = 16'hABC6;
    wait_tag(t0 + 1, 200, ok);
    check("hold_tag1_seen", 32'(ok), 32'd1);
    check("hold_tag1_cycle", tag_cyc - c0, WORDS + 3);
    check("hold_wr1", wr_cnt, WORDS);
    push_expect(16'hABC6);
    @(posedge clk); #1;
    c1 = cyc;
    @(negedge clk);
    check("hold_idle_busy", 32'(fsm_busy), 32'd1);
    check("hold_idle_noreq", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    miss_detected = 1'b0; miss_address = 16'h0;
    @(negedge clk);
    check("hold_second_req", 32'(mem_req), 32'd1);
    wait_tag(t0 + 2, 200, ok);
    check("hold_tag2_seen", 32'(ok), 32'd1);
    check("hold_tag2_cycle", tag_cyc - c1, WORDS + 3);
    check("hold_first2", first_req_addr, CWF ? 16'hABC6 : 16'hABC0);
    @(negedge clk); #1;
    check("hold_wr2", wr_cnt, WORDS);

    // Asynchronous reset in WAIT after three words
    mem_lat = 12; mem_gap = 0; mem_spur = 1'b0;
    @(posedge clk); #1;
    miss_detected = 1'b1; miss_address = 16'h3C00;
    push_expect(16'h3C00);
    t0 = tag_cnt;
    @(posedge clk); #1;
    miss_detected = 1'b0; miss_address = 16'h0;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (wr_cnt >= 3);
    end
    check("abort_three_words", wr_cnt, 32'd3);
    check("abort_in_wait", 32'(mem_req), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(fsm_busy), 32'd0);
    check("abort_req", 32'(mem_req), 32'd0);
    check("abort_addr", mem_addr, 32'h0);
    check("abort_wr", 32'(write_data_array), 32'd0);
    check("abort_tag", 32'(write_tag_array), 32'd0);
    check("abort_idx", 32'(fill_word_idx), 32'd0);
    repeat (2) @(negedge clk);
    req_due.delete(); req_addr.delete();
    exp_addr_q.delete(); exp_idx_q.delete(); exp_data_q.delete();
    spur_pending = 1'b0;
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    check("abort_no_tag", tag_cnt, t0);
    check("abort_no_more_writes", wr_cnt, 32'd3);
    run_fill(16'h2468, 3, 0, 1'b0, CWF ? 16'h2468 : 16'h2460, WORDS + 3 + 1);

    // 32-bit words, 4-word block, latency 1
    if (CWF) begin
      exp2_addr = '{16'h00F4, 16'h00F8, 16'h00FC, 16'h00F0};
      exp2_idx  = '{2'd1, 2'd2, 2'd3, 2'd0};
    end else begin
      exp2_addr = '{16'h00F0, 16'h00F4, 16'h00F8, 16'h00FC};
      exp2_idx  = '{2'd0, 2'd1, 2'd2, 2'd3};
    end
    @(posedge clk); #1;
    m2_miss = 1'b1; m2_addr = 16'h00F4;
    @(posedge clk); #1;
    m2_miss = 1'b0; m2_addr = 16'h0;
    for (int k = 0; k < 5; k++) begin
      m2_valid = (k > 0);
      m2_data = 32'hC0DE_0000 + 32'(k);
      @(negedge clk);
      if (k < 4) begin
        check("w32_req", 32'(b2_req), 32'd1);
        check("w32_addr", b2_mem_addr, exp2_addr[k]);
      end
      if (k > 0) begin
        check("w32_wr", 32'(b2_wr), 32'd1);
        check("w32_idx", 32'(b2_idx), 32'(exp2_idx[k-1]));
        check("w32_data", b2_fill_data, 32'hC0DE_0000 + 32'(k));
      end
      @(posedge clk); #1;
    end
    m2_valid = 1'b0; m2_data = 32'h0;
    @(negedge clk);
    check("w32_tag", 32'(b2_tag), 32'd1);
    @(negedge clk);
    check("w32_idle", 32'(b2_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
